// File: rtl/serial_shift_engine.sv
// serial_shift_engine
//   WIDTH-bit shift register with a built-in tick divider. It can be parallel
//   loaded while idle. After a start it makes exactly WIDTH shifts, one every
//   DIV clk cycles, in PISO, SIPO or rotate mode.
//
// Parameters
//   WIDTH      register width (>= 2)
//   DIV        clk cycles per shift tick (>= 1)
//   MSB_FIRST  1: shift toward MSB, ser_out = reg[WIDTH-1]
//              0: shift toward LSB, ser_out = reg[0]
//
// Ports
//   clk      system clock, rising edge
//   rst      asynchronous reset, active low
//   load     parallel load request (idle only, wins over start)
//   par_in   parallel load data
//   start    begin a WIDTH-shift run (idle only)
//   mode     00 PISO, 01 SIPO, 10 rotate, 11 reserved (start ignored)
//   abort    end the current run with no further shift and no done
//   ser_in   serial input bit for SIPO
//   ser_out  outgoing bit of the register
//   par_out  register contents
//   busy     high while a run is in progress
//   done     one-cycle pulse on run completion
module serial_shift_engine #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DIV       = 50000000,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] par_in,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic             abort,
   input  logic             ser_in,
   output logic             ser_out,
   output logic [WIDTH-1:0] par_out,
   output logic             busy,
   output logic             done
);

   localparam int unsigned   TW        = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned   BW        = $clog2(WIDTH + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
   localparam logic [BW-1:0] BIT_FULL  = BW'(WIDTH);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   typedef enum logic [1:0] {
      MODE_PISO = 2'b00,
      MODE_SIPO = 2'b01,
      MODE_ROT  = 2'b10,
      MODE_RSVD = 2'b11
   } mode_t;

   state_t           state_q, state_d;
   mode_t            mode_q, mode_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [TW-1:0]    tick_q, tick_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic             done_q, done_d;
   logic             tick;
   logic             out_bit;
   logic             fill;

   assign out_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
   assign tick    = (tick_q == TICK_LAST);

   assign ser_out = out_bit;
   assign par_out = shreg_q;
   assign busy    = (state_q == SHIFT);
   assign done    = done_q;

   // Bit entering the register on a shift, chosen by the mode latched at start.
   always_comb begin
      fill = 1'b0;
      unique case (mode_q)
         MODE_PISO: fill = 1'b0;
         MODE_SIPO: fill = ser_in;
         MODE_ROT:  fill = out_bit;
         default:   fill = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      shreg_d = shreg_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (load) begin
               shreg_d = par_in;
            end else if (start && (mode != 2'b11)) begin
               mode_d  = mode_t'(mode);
               bit_d   = BIT_FULL;
               tick_d  = '0;
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            // abort takes priority over a coincident tick: no shift, no done
            if (abort) begin
               state_d = IDLE;
            end else begin
               tick_d = tick ? '0 : tick_q + TW'(1);
               if (tick) begin
                  if (MSB_FIRST) begin
                     shreg_d = {shreg_q[WIDTH-2:0], fill};
                  end else begin
                     shreg_d = {fill, shreg_q[WIDTH-1:1]};
                  end
                  bit_d = bit_q - BW'(1);
                  if (bit_q == BW'(1)) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         mode_q  <= MODE_PISO;
         shreg_q <= '0;
         tick_q  <= '0;
         bit_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         shreg_q <= shreg_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_serial_shift_engine.sv
// tb_serial_shift_engine
//   Two engine instances (WIDTH=8/DIV=4/MSB first and WIDTH=8/DIV=1/LSB first),
//   each with its own inputs. A behavioural model follows every cycle, and
//   directed scenarios add fixed expected values.
module tb_serial_shift_engine;

   localparam int unsigned W = 8;

   logic             clk;
   logic             rst;
   logic [1:0]       ld, st, ab, si;
   logic [W-1:0]     pin [2];
   logic [1:0]       md  [2];
   logic             so0, so1, bz0, bz1, dn0, dn1;
   logic [W-1:0]     po0, po1;

   // reference model state, one entry per instance
   logic [W-1:0]     m_reg  [2];
   logic             m_busy [2];
   logic             m_done [2];
   int unsigned      m_el   [2];
   int unsigned      m_sh   [2];
   logic [1:0]       m_mode [2];

   int unsigned      n_vec;
   int unsigned      n_err;
   int unsigned      bits [8] = '{0, 1, 0, 0, 1, 0, 1, 0};
   int unsigned      sipo [8] = '{1, 1, 0, 0, 1, 0, 1, 0};

   serial_shift_engine #(.WIDTH(W), .DIV(4), .MSB_FIRST(1'b1)) u_dut0 (
      .clk(clk), .rst(rst), .load(ld[0]), .par_in(pin[0]), .start(st[0]),
      .mode(md[0]), .abort(ab[0]), .ser_in(si[0]), .ser_out(so0),
      .par_out(po0), .busy(bz0), .done(dn0));

   serial_shift_engine #(.WIDTH(W), .DIV(1), .MSB_FIRST(1'b0)) u_dut1 (
      .clk(clk), .rst(rst), .load(ld[1]), .par_in(pin[1]), .start(st[1]),
      .mode(md[1]), .abort(ab[1]), .ser_in(si[1]), .ser_out(so1),
      .par_out(po1), .busy(bz1), .done(dn1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int unsigned div_of(input int i);
      return (i == 0) ? 4 : 1;
   endfunction

   function automatic bit msb_first_of(input int i);
      return (i == 0);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_reg[i]  = '0;
         m_busy[i] = 1'b0;
         m_done[i] = 1'b0;
         m_el[i]   = 0;
         m_sh[i]   = 0;
         m_mode[i] = 2'b00;
      end
   endtask

   // One rising edge of behaviour: a run is a sequence of WIDTH shifts, one
   // every DIV cycles counted from the accepting edge.
   task automatic model_step();
      logic [W-1:0] r;
      int unsigned  outb, fillb;
      if (!rst) begin
         model_reset();
         return;
      end
      for (int i = 0; i < 2; i++) begin
         m_done[i] = 1'b0;
         if (!m_busy[i]) begin
            if (ld[i]) begin
               m_reg[i] = pin[i];
            end else if (st[i] && md[i] != 2'b11) begin
               m_busy[i] = 1'b1;
               m_mode[i] = md[i];
               m_el[i]   = 0;
               m_sh[i]   = 0;
            end
         end else if (ab[i]) begin
            m_busy[i] = 1'b0;
         end else begin
            m_el[i]++;
            if (m_el[i] % div_of(i) == 0) begin
               r    = m_reg[i];
               outb = msb_first_of(i) ? (int'(r) >> (W - 1)) & 1 : int'(r) & 1;
               case (m_mode[i])
                  2'b01:   fillb = int'(si[i]);
                  2'b10:   fillb = outb;
                  default: fillb = 0;
               endcase
               if (msb_first_of(i)) m_reg[i] = W'((int'(r) << 1) | fillb);
               else                 m_reg[i] = W'((int'(r) >> 1) | (fillb << (W - 1)));
               m_sh[i]++;
               if (m_sh[i] == W) begin
                  m_busy[i] = 1'b0;
                  m_done[i] = 1'b1;
               end
            end
         end
      end
   endtask

   function automatic logic exp_ser(input int i);
      return msb_first_of(i) ? m_reg[i][W-1] : m_reg[i][0];
   endfunction

   task automatic check_all();
      check("par_out0", 32'(po0), 32'(m_reg[0]));
      check("ser_out0", 32'(so0), 32'(exp_ser(0)));
      check("busy0",    32'(bz0), 32'(m_busy[0]));
      check("done0",    32'(dn0), 32'(m_done[0]));
      check("par_out1", 32'(po1), 32'(m_reg[1]));
      check("ser_out1", 32'(so1), 32'(exp_ser(1)));
      check("busy1",    32'(bz1), 32'(m_busy[1]));
      check("done1",    32'(dn1), 32'(m_done[1]));
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic idle_inputs();
      ld = '0; st = '0; ab = '0; si = '0;
      for (int i = 0; i < 2; i++) begin
         pin[i] = '0;
         md[i]  = 2'b00;
      end
   endtask

   task automatic load_start(input int i, input logic [W-1:0] val, input logic [1:0] m);
      ld[i] = 1'b1; pin[i] = val;
      cyc();
      ld[i] = 1'b0; st[i] = 1'b1; md[i] = m;
      cyc();
      st[i] = 1'b0;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      idle_inputs();
      rst = 1'b0;
      model_reset();
      #1;
      check_all();
      repeat (2) cyc();
      rst = 1'b1;
      cyc();

      // reset mid-run
      load_start(0, 8'hFF, 2'b00);
      repeat (8) cyc();
      check("pre_rst_par", 32'(po0), 32'h0000_00FC);
      rst = 1'b0;
      #1;
      model_reset();
      check_all();
      check("rst_par", 32'(po0), 32'h0);
      repeat (2) cyc();
      rst = 1'b1;
      repeat (40) cyc();

      // PISO
      load_start(0, 8'hA5, 2'b00);
      check("piso_first", 32'(so0), 32'h1);
      for (int n = 0; n < 8; n++) begin
         repeat (4) cyc();
         check("piso_ser", 32'(so0), 32'(bits[n]));
         check("piso_done", 32'(dn0), (n == 7) ? 32'h1 : 32'h0);
      end
      cyc();
      check("piso_done_clr", 32'(dn0), 32'h0);
      check("piso_par", 32'(po0), 32'h0);

      // SIPO, MSB first then LSB first
      st[0] = 1'b1; md[0] = 2'b01;
      cyc();
      st[0] = 1'b0;
      for (int n = 0; n < 8; n++) begin
         si[0] = sipo[n][0];
         repeat (4) cyc();
      end
      check("sipo_msb", 32'(po0), 32'h0000_00CA);
      check("sipo_done", 32'(dn0), 32'h1);
      st[1] = 1'b1; md[1] = 2'b01;
      cyc();
      st[1] = 1'b0;
      for (int n = 0; n < 8; n++) begin
         si[1] = sipo[n][0];
         cyc();
      end
      check("sipo_lsb", 32'(po1), 32'h0000_0053);
      si = '0;
      cyc();

      // rotate
      load_start(0, 8'h81, 2'b10);
      repeat (12) cyc();
      check("rot_3", 32'(po0), 32'h0000_000C);
      repeat (20) cyc();
      check("rot_end", 32'(po0), 32'h0000_0081);
      check("rot_done", 32'(dn0), 32'h1);
      cyc();

      // abort on the third tick edge
      load_start(0, 8'hFF, 2'b00);
      repeat (11) cyc();
      ab[0] = 1'b1;
      cyc();
      ab[0] = 1'b0;
      check("abort_par", 32'(po0), 32'h0000_00FC);
      check("abort_busy", 32'(bz0), 32'h0);
      check("abort_done", 32'(dn0), 32'h0);
      repeat (40) cyc();

      // arbitration
      ld[0] = 1'b1; st[0] = 1'b1; pin[0] = 8'h3C; md[0] = 2'b00;
      cyc();
      ld[0] = 1'b0; st[0] = 1'b0;
      check("ld_st_par", 32'(po0), 32'h0000_003C);
      check("ld_st_busy", 32'(bz0), 32'h0);
      st[0] = 1'b1; md[0] = 2'b11;
      cyc();
      st[0] = 1'b0;
      cyc();
      check("rsvd_busy", 32'(bz0), 32'h0);
      st[0] = 1'b1; md[0] = 2'b00;
      cyc();
      st[0] = 1'b0; md[0] = 2'b11;
      ld[0] = 1'b1; pin[0] = 8'h00;
      repeat (4) cyc();
      check("ld_in_shift", 32'(po0), 32'h0000_0078);
      ld[0] = 1'b0;
      repeat (28) cyc();
      check("ld_in_shift_done", 32'(dn0), 32'h1);
      cyc();

      // DIV=1 run completes 8 edges after the start edge
      st[1] = 1'b1; md[1] = 2'b00;
      cyc();
      st[1] = 1'b0;
      repeat (7) cyc();
      check("div1_early", 32'(dn1), 32'h0);
      cyc();
      check("div1_done", 32'(dn1), 32'h1);
      cyc();

      // randomized traffic on both instances
      for (int k = 0; k < 800; k++) begin
         if (k == 400) begin
            rst = 1'b0;
            #1;
            model_reset();
            check_all();
            cyc();
            rst = 1'b1;
         end
         for (int i = 0; i < 2; i++) begin
            ld[i]  = ($urandom_range(0, 9) == 0);
            pin[i] = W'($urandom);
            st[i]  = ($urandom_range(0, 3) == 0);
            md[i]  = 2'($urandom_range(0, 3));
            ab[i]  = ($urandom_range(0, 59) == 0);
            si[i]  = 1'($urandom_range(0, 1));
         end
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/serial_shift_engine.md
# serial_shift_engine

Parametrised shift engine replacing the fixed 8-bit parallel-in/serial-out chain. It holds a WIDTH-bit register that can be parallel-loaded, then shifted exactly WIDTH times at a divided tick rate. Each run is in one of three modes: parallel-in/serial-out, serial-in/parallel-out, or rotate. It sits between board switches/buttons and LEDs (or a serial pin), with the tick divider built in so no separate divided clock is needed.

## Interface
- WIDTH, default 8: register width, ≥2.
- DIV, default 50000000: clk cycles per shift tick, ≥1 (1 = every cycle).
- MSB_FIRST, default 1: 1 = shift toward MSB (ser_out = reg[WIDTH-1]); 0 = shift toward LSB (ser_out = reg[0]).

Ports:
- clk  in  1  single system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- load  in  1  parallel load request (IDLE only).
- par_in  in  WIDTH  parallel load data.
- start  in  1  begin a WIDTH-shift run (IDLE only).
- mode  in  2  00 PISO, 01 SIPO, 10 rotate, 11 reserved; sampled on accepted start.
- abort  in  1  terminate run.
- ser_in  in  1  serial data for SIPO.
- ser_out  out  1  current outgoing bit (combinational from register).
- par_out  out  WIDTH  register contents.
- busy  out  1  high while in SHIFT.
- done  out  1  one-cycle pulse on run completion.

## Operation
- States: IDLE, SHIFT. `busy` = (state == SHIFT).
- IDLE:
  - load=1: reg <= par_in on that edge, regardless of tick.
  - load=0, start=1, mode≠11: latch mode, bit_cnt <= WIDTH, tick_cnt <= 0, go to SHIFT.
  - start with mode=11 is ignored.
  - load and start together: load wins, start ignored.
- SHIFT:
  - tick_cnt counts 0..DIV-1 and wraps; tick = (tick_cnt == DIV-1).
  - On tick: shift once, bit_cnt decrements.
  - load, start and mode changes are ignored.
- Shift (MSB_FIRST=1): reg <= {reg[WIDTH-2:0], fill}. MSB_FIRST=0: reg <= {fill, reg[WIDTH-1:1]}.
- fill by mode:
  - PISO: 0.
  - SIPO: ser_in sampled at the tick edge.
  - Rotate: the outgoing bit.
- Completion: the tick that takes bit_cnt 1→0 performs the final shift, returns to IDLE and sets done=1 on the same edge. done clears on the next edge.
- abort in SHIFT: go to IDLE on the next edge, no shift that edge (abort beats a coincident tick), register keeps its contents, done stays 0. abort in IDLE has no effect.
- Widths:
  - tick_cnt: $clog2(DIV) bits, minimum 1.
  - bit_cnt: $clog2(WIDTH+1) bits.
  - No arithmetic overflow is permitted: wrap only by explicit compare.

## Timing
- Reset values (asserted asynchronously, immediate): reg=0, par_out=0, ser_out=0, state=IDLE, busy=0, done=0, tick_cnt=0, bit_cnt=0, latched mode=00.
- rst low mid-run: run lost, no done.
- Release is synchronous in effect: the first functional edge is the first rising clk edge with rst high.
- Load latency: par_out reflects par_in 1 cycle after the load edge.
- Start accepted at edge E:
  - busy=1 from E.
  - Shift n occurs at edge E + n·DIV, for n=1..WIDTH.
  - Final shift, done=1 and busy=0 all at E + WIDTH·DIV.
  - done low at E + WIDTH·DIV + 1.
- ser_out changes only on load or shift edges.
- A new start is accepted on the edge immediately after done's cycle begins, i.e. back-to-back runs have a 1-cycle IDLE gap.

## Test plan
All cases use WIDTH=8, DIV=4, MSB_FIRST=1 unless stated.

1. Reset: load 0xFF, start PISO, drop rst after 2 ticks -> par_out=0x00, busy=0, done=0 immediately; no done after rst release.
2. PISO: load 0xA5, start mode 00 at edge E -> ser_out after edges E+4·n reads 0,1,0,0,1,0,1,0 (initial 1). done high only in the cycle after E+32. par_out=0x00.
3. SIPO: start mode 01, drive ser_in 1,1,0,0,1,0,1,0 at successive ticks -> par_out=0xCA at done. With MSB_FIRST=0, same stream -> 0x53.
4. Rotate: load 0x81, start mode 10 -> par_out=0x0C after 3 ticks, 0x81 at done.
5. Abort: load 0xFF, PISO, assert abort on the 3rd tick edge -> par_out=0xFC (2 shifts only), busy=0 next cycle, done never pulses.
6. Arbitration: load=1 with start=1 and par_in=0x3C -> par_out=0x3C, busy stays 0. Start with mode 11 -> ignored. load 0x00 during SHIFT -> ignored, run completes normally. DIV=1 run -> done at E+8.
